bram_access_arbiter: RTL and testbench

- Shares one 256x16 BRAM (separate write and read ports, one common clock) between two requesters, A and B.
- Write port and read port are arbitrated independently, so one requester can write while the other reads in the same cycle.
- Resolves read-during-write hazards on the same address and returns tagged read data.
- Includes a clear sequencer that fills the whole array with a constant.
- Sits between the BRAM primitive and its users, for example a waveform-table loader and a playback engine.

---
 rtl/bram_access_arbiter.sv | 134 +++++++++++++
 tb/tb_bram_access_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_access_arbiter.sv
// Two-requester front end for a 256x16 simple-dual-port BRAM: independent
// round-robin write/read arbitration, same-address hazard stall, tagged reads, array clear.
module bram_access_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] a_mask,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [DATA_W-1:0] b_mask,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              ram_we,
  output logic              ram_wclke,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_mask,
  output logic              ram_re,
  output logic              ram_rclke,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata
);

  // state | meaning
  // IDLE  | requesters arbitrated onto the write and read ports
  // CLEAR | sequencer owns the write port, one address per cycle; no grants
  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t        state;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              a_rd_q, b_rd_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  logic              arb_en, clearing;
  logic              a_wr_req, b_wr_req, a_wr_gnt, b_wr_gnt, wr_any;
  logic              a_rd_req, b_rd_req, a_rd_pick, b_rd_pick;
  logic              a_rd_gnt, b_rd_gnt, rd_hazard;
  logic [ADDR_W-1:0] wr_addr_sel, rd_addr_sel;

  assign arb_en   = !rst && (state == IDLE);
  assign clearing = !rst && (state == CLEAR);

  // Pointer value 0 favours A, 1 favours B.
  assign a_wr_req = arb_en & a_req & a_we;
  assign b_wr_req = arb_en & b_req & b_we;
  assign a_wr_gnt = a_wr_req & (!b_wr_req | !wr_ptr);
  assign b_wr_gnt = b_wr_req & (!a_wr_req | wr_ptr);
  assign wr_any   = a_wr_gnt | b_wr_gnt;
  assign wr_addr_sel = a_wr_gnt ? a_addr : b_addr;

  assign a_rd_req  = arb_en & a_req & !a_we;
  assign b_rd_req  = arb_en & b_req & !b_we;
  assign a_rd_pick = a_rd_req & (!b_rd_req | !rd_ptr);
  assign b_rd_pick = b_rd_req & (!a_rd_req | rd_ptr);
  assign rd_addr_sel = a_rd_pick ? a_addr : b_addr;

  // Stalling the read one cycle lets it see the new word instead of the old one.
  assign rd_hazard = wr_any && (a_rd_pick || b_rd_pick) && (rd_addr_sel == wr_addr_sel);
  assign a_rd_gnt  = a_rd_pick & !rd_hazard;
  assign b_rd_gnt  = b_rd_pick & !rd_hazard;

  assign a_gnt = a_wr_gnt | a_rd_gnt;
  assign b_gnt = b_wr_gnt | b_rd_gnt;

  assign ram_we    = wr_any | clearing;
  assign ram_wclke = wr_any | clearing;
  assign ram_waddr = clearing ? clr_addr : wr_addr_sel;
  assign ram_wdata = clearing ? CLEAR_VALUE : (a_wr_gnt ? a_wdata : b_wdata);
  assign ram_mask  = clearing ? '0 : (a_wr_gnt ? a_mask : b_mask);

  assign ram_re    = a_rd_gnt | b_rd_gnt;
  assign ram_rclke = a_rd_gnt | b_rd_gnt;
  assign ram_raddr = rd_addr_sel;

  assign clr_busy = (state == CLEAR);

  assign a_rvalid = a_rd_q;
  assign b_rvalid = b_rd_q;
  assign a_rdata  = a_rd_q ? ram_rdata : a_rdata_q;
  assign b_rdata  = b_rd_q ? ram_rdata : b_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clr_addr  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      a_rd_q    <= 1'b0;
      b_rd_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == {ADDR_W{1'b1}}) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (a_wr_req && b_wr_req) wr_ptr <= a_wr_gnt;
      if (a_rd_req && b_rd_req && !rd_hazard) rd_ptr <= a_rd_gnt;

      a_rd_q <= a_rd_gnt;
      b_rd_q <= b_rd_gnt;
      if (a_rd_q) a_rdata_q <= ram_rdata;
      if (b_rd_q) b_rdata_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Directed bench for bram_access_arbiter with a behavioural 256x16 masked BRAM
// (registered read, mask bit 1 keeps the stored bit).
module tb_bram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [7:0]  a_addr = '0;
  logic [15:0] a_wdata = '0, a_mask = '0;
  logic        a_gnt, a_rvalid;
  logic [15:0] a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [7:0]  b_addr = '0;
  logic [15:0] b_wdata = '0, b_mask = '0;
  logic        b_gnt, b_rvalid;
  logic [15:0] b_rdata;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        ram_we, ram_wclke, ram_re, ram_rclke;
  logic [7:0]  ram_waddr, ram_raddr;
  logic [15:0] ram_wdata, ram_mask;
  logic [15:0] ram_rdata = '0;

  logic        mem_clr = 1'b1;
  logic [15:0] mem [0:255];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bram_access_arbiter #(.ADDR_W(8), .DATA_W(16), .CLEAR_VALUE(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_we(ram_we), .ram_wclke(ram_wclke), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_mask(ram_mask),
    .ram_re(ram_re), .ram_rclke(ram_rclke), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    end else begin
      if (ram_we && ram_wclke)
        mem[ram_waddr] <= (mem[ram_waddr] & ram_mask) | (ram_wdata & ~ram_mask);
      if (ram_re && ram_rclke)
        ram_rdata <= mem[ram_raddr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr_a(input logic [7:0] addr, input logic [15:0] data, input logic [15:0] mask);
    step();
    a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data; a_mask = mask;
    #1 chk("wr_a_gnt", {31'd0, a_gnt}, 32'd1);
    step();
    a_req = 1'b0;
  endtask

  task automatic rd_a(input logic [7:0] addr, input logic [15:0] exp, input string tag);
    step();
    a_req = 1'b1; a_we = 1'b0; a_addr = addr;
    #1 chk({tag, "_gnt"}, {31'd0, a_gnt}, 32'd1);
    step();
    a_req = 1'b0;
    #1 chk({tag, "_rvalid"}, {31'd0, a_rvalid}, 32'd1);
    chk({tag, "_rdata"}, {16'd0, a_rdata}, {16'd0, exp});
  endtask

  initial begin
    int n;
    int bad;

    // Reset: A requesting a write must still see no grant while rst is high.
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h77;
    step(); step();
    #1;
    chk("rst_a_gnt",    {31'd0, a_gnt},    32'd0);
    chk("rst_b_gnt",    {31'd0, b_gnt},    32'd0);
    chk("rst_ram_we",   {31'd0, ram_we},   32'd0);
    chk("rst_ram_re",   {31'd0, ram_re},   32'd0);
    chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_a_rdata",  {16'd0, a_rdata},  32'd0);
    chk("rst_b_rdata",  {16'd0, b_rdata},  32'd0);
    step();
    rst = 1'b0; mem_clr = 1'b0; a_req = 1'b0; a_we = 1'b0;

    // 1: A writes, B reads it back
    step();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 16'h1234; a_mask = 16'h0000;
    #1 chk("t1_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("t1_ram_waddr", {24'd0, ram_waddr}, 32'h10);
    chk("t1_ram_wdata", {16'd0, ram_wdata}, 32'h1234);
    step();
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 8'h10;
    #1 chk("t1_b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("t1_ram_re", {31'd0, ram_re}, 32'd1);
    step();
    b_req = 1'b0;
    #1 chk("t1_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("t1_b_rdata", {16'd0, b_rdata}, 32'h1234);
    step();
    #1 chk("t1_b_rvalid_off", {31'd0, b_rvalid}, 32'd0);
    chk("t1_b_rdata_hold", {16'd0, b_rdata}, 32'h1234);

    // 2: contended writes alternate A, B, A, B
    step();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 16'hAAAA; a_mask = 16'h0000;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h21; b_wdata = 16'h5555; b_mask = 16'h0000;
    #1 chk("t2_c0", {30'd0, a_gnt, b_gnt}, 32'b10);
    step();
    #1 chk("t2_c1", {30'd0, a_gnt, b_gnt}, 32'b01);
    step();
    #1 chk("t2_c2", {30'd0, a_gnt, b_gnt}, 32'b10);
    step();
    #1 chk("t2_c3", {30'd0, a_gnt, b_gnt}, 32'b01);
    step();
    a_req = 1'b0; b_req = 1'b0;
    // contended reads also alternate, starting with A
    step();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h20;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h21;
    #1 chk("t2_rd0", {30'd0, a_gnt, b_gnt}, 32'b10);
    step();
    #1 chk("t2_rd1", {30'd0, a_gnt, b_gnt}, 32'b01);
    chk("t2_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("t2_a_rdata", {16'd0, a_rdata}, 32'hAAAA);
    step();
    a_req = 1'b0; b_req = 1'b0;
    #1 chk("t2_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("t2_b_rdata", {16'd0, b_rdata}, 32'h5555);
    chk("t2_a_rvalid_off", {31'd0, a_rvalid}, 32'd0);

    // 3: read of the address being written is stalled one cycle
    step();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h30; a_wdata = 16'hBEEF; a_mask = 16'h0000;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h30;
    #1 chk("t3_gnt_hazard", {30'd0, a_gnt, b_gnt}, 32'b10);
    chk("t3_ram_re_hazard", {31'd0, ram_re}, 32'd0);
    step();
    a_req = 1'b0;
    #1 chk("t3_b_gnt_next", {31'd0, b_gnt}, 32'd1);
    step();
    b_req = 1'b0;
    #1 chk("t3_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("t3_b_rdata", {16'd0, b_rdata}, 32'hBEEF);

    // 4: different addresses proceed together
    step();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h40; a_wdata = 16'h1111; a_mask = 16'h0000;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h41;
    #1 chk("t4_gnt", {30'd0, a_gnt, b_gnt}, 32'b11);
    chk("t4_ram_en", {30'd0, ram_we, ram_re}, 32'b11);
    chk("t4_ram_waddr", {24'd0, ram_waddr}, 32'h40);
    chk("t4_ram_raddr", {24'd0, ram_raddr}, 32'h41);
    step();
    a_req = 1'b0; b_req = 1'b0;
    #1 chk("t4_b_rdata", {16'd0, b_rdata}, 32'h0000);
    rd_a(8'h40, 16'h1111, "t4_rb40");

    // 5: masked write keeps the low byte
    step();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h50; a_wdata = 16'hFFFF; a_mask = 16'h00FF;
    #1 chk("t5_ram_mask", {16'd0, ram_mask}, 32'h00FF);
    step();
    a_req = 1'b0; a_mask = 16'h0000;
    rd_a(8'h50, 16'hFF00, "t5_rb50");

    // 6: full clear with A holding a read request
    step();
    clr_start = 1'b1;
    #1 chk("t6_busy_pulse_cycle", {31'd0, clr_busy}, 32'd0);
    step();
    clr_start = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    #1 chk("t6_clr_first_we", {31'd0, ram_we}, 32'd1);
    chk("t6_clr_first_data", {16'd0, ram_wdata}, 32'h0000);
    n = 0; bad = 0;
    while (clr_busy && n < 300) begin
      if (a_gnt || b_gnt) bad++;
      if (ram_waddr !== n[7:0] || ram_mask !== 16'h0000 || !ram_we) bad++;
      n++;
      step();
      #1;
    end
    chk("t6_busy_cycles", n, 32'd256);
    chk("t6_clr_bad", bad, 32'd0);
    chk("t6_a_gnt_after", {31'd0, a_gnt}, 32'd1);
    step();
    a_req = 1'b0;
    #1 chk("t6_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("t6_a_rdata", {16'd0, a_rdata}, 32'h0000);
    bad = 0;
    for (int i = 0; i <= 256; i++) begin
      step();
      if (i < 256) begin
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'(i);
      end else begin
        b_req = 1'b0;
      end
      #1;
      if (i < 256 && !b_gnt) bad++;
      if (i > 0 && (!b_rvalid || b_rdata !== 16'h0000)) bad++;
    end
    chk("t6_sweep_bad", bad, 32'd0);

    // 6b: reset at clear cycle 100 aborts, rest of array untouched
    wr_a(8'h62, 16'h1111, 16'h0000);
    wr_a(8'h63, 16'h2222, 16'h0000);
    wr_a(8'hC8, 16'h5A5A, 16'h0000);
    step();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    #1 chk("t6b_busy", {31'd0, clr_busy}, 32'd1);
    for (int k = 1; k < 100; k++) step();
    rst = 1'b1;
    #1 chk("t6b_busy_abort", {31'd0, clr_busy}, 32'd0);
    chk("t6b_we_abort", {31'd0, ram_we}, 32'd0);
    step();
    rst = 1'b0;
    rd_a(8'h62, 16'h0000, "t6b_rb62");
    rd_a(8'h63, 16'h2222, "t6b_rb63");
    rd_a(8'hC8, 16'h5A5A, "t6b_rbC8");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
